// File: rtl/fetch_queue.sv
// Instruction fetch stage with an N-entry prefetch buffer.
// Sequential fetch, redirect flush, misaligned-target exception marker.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     imem_en,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [XLEN-1:0]          instr_out,
  output logic [XLEN-1:0]          pc_out,
  output logic                     misaligned_out,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic            buf_mis   [DEPTH];

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic            halted;

  logic [CW:0]     credits;
  logic            mis_tgt;
  logic            deq;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_instr;
  logic [XLEN-1:0] wr_pc;
  logic            wr_mis;

  // Buffered entries plus the outstanding request bound the issue rate.
  assign credits   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_en   = reset_n && !halted && !redirect_valid
                   && (credits < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign mis_tgt = redirect_pc[1:0] != 2'b00;

  assign instr_valid    = count != '0;
  assign instr_out      = buf_instr[rd_ptr];
  assign pc_out         = buf_pc[rd_ptr];
  assign misaligned_out = instr_valid && buf_mis[rd_ptr];
  assign occupancy      = count;

  assign deq = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = wr_ptr;
    wr_instr = imem_rdata;
    wr_pc    = inflight_pc;
    wr_mis   = 1'b0;
    if (redirect_valid) begin
      wr_en    = mis_tgt;
      wr_idx   = '0;
      wr_instr = XLEN'(32'h0000_0013);
      wr_pc    = redirect_pc;
      wr_mis   = 1'b1;
    end else begin
      wr_en = inflight;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      buf_instr[wr_idx] <= wr_instr;
      buf_pc[wr_idx]    <= wr_pc;
      buf_mis[wr_idx]   <= wr_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
      if (mis_tgt) begin
        wr_ptr <= AW'(1);
        count  <= CW'(1);
        halted <= 1'b1;
      end else begin
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
        halted   <= 1'b0;
      end
    end else begin
      if (deq)
        rd_ptr <= rd_ptr + AW'(1);
      if (inflight)
        wr_ptr <= wr_ptr + AW'(1);
      count    <= count + CW'(inflight) - CW'(deq);
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        misaligned_out;
  logic [2:0]  occupancy;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out),
    .misaligned_out(misaligned_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle latency, word = inverted address.
  always @(posedge clk)
    imem_rdata <= imem_en ? ~imem_addr : 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fetch = '0;
  logic [31:0] m_ipc = '0;
  logic        m_infl = 1'b0;
  logic        m_halted = 1'b0;
  logic        m_known = 1'b0;

  int checks = 0;
  int fails = 0;
  int issued = 0;
  logic [31:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic rdy,
                      input logic rv, input logic [31:0] rpc);
    logic iss;
    logic deq;
    ent_t e;
    reset_n = rn;
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    iss = rn && !m_halted && !rv
        && (m_q.size() + int'(m_infl)) < DEPTH;
    chk("imem_en", {31'b0, imem_en}, {31'b0, iss});
    if (iss) begin
      chk("imem_addr", imem_addr, m_fetch);
      issued++;
      last_addr = imem_addr;
    end
    if (m_known) begin
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
      chk("occupancy", {29'b0, occupancy}, 32'(m_q.size()));
      if (m_q.size() != 0) begin
        chk("pc_out", pc_out, m_q[0].pc);
        chk("instr_out", instr_out, m_q[0].instr);
        chk("misaligned", {31'b0, misaligned_out}, {31'b0, m_q[0].mis});
      end else begin
        chk("misaligned", {31'b0, misaligned_out}, 32'h0);
      end
    end
    @(posedge clk);
    deq = m_q.size() != 0 && rdy && !rv;
    if (!rn) begin
      m_fetch = RPC;
      m_q.delete();
      m_infl = 1'b0;
      m_halted = 1'b0;
      m_known = 1'b1;
    end else if (rv) begin
      m_q.delete();
      m_infl = 1'b0;
      if (rpc[1:0] == 2'b00) begin
        m_fetch = rpc;
        m_halted = 1'b0;
      end else begin
        e.instr = 32'h0000_0013;
        e.pc = rpc;
        e.mis = 1'b1;
        m_q.push_back(e);
        m_halted = 1'b1;
      end
    end else begin
      if (deq) void'(m_q.pop_front());
      if (m_infl) begin
        e.instr = ~m_ipc;
        e.pc = m_ipc;
        e.mis = 1'b0;
        m_q.push_back(e);
      end
      m_infl = iss;
      if (iss) begin
        m_ipc = m_fetch;
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;
    logic rv;
    logic rn;

    // Reset and streaming startup
    do_reset();
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_occ", {29'b0, occupancy}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'h1);
    chk("first_pc", pc_out, 32'h4000_0000);
    chk("first_instr", instr_out, 32'hBFFF_FFFF);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure from reset
    do_reset();
    issued = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_issued", 32'(issued), 32'd4);
    chk("bp_occ", {29'b0, occupancy}, 32'd4);
    chk("bp_en", {31'b0, imem_en}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("bp_resume", last_addr, 32'h4000_0010);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with 2 buffered and 1 in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_rd_occ", {29'b0, occupancy}, 32'd2);
    step(1'b1, 1'b0, 1'b1, 32'h4000_0100);
    chk("rd_flush", {31'b0, instr_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rd_r3_valid", {31'b0, instr_valid}, 32'h1);
    chk("rd_r3_pc", pc_out, 32'h4000_0100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with an accepted dequeue
    step(1'b1, 1'b1, 1'b1, 32'h4000_0300);
    chk("rdq_occ", {29'b0, occupancy}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rdq_pc", pc_out, 32'h4000_0300);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned target, halt, then recover
    step(1'b1, 1'b0, 1'b1, 32'h4000_0102);
    chk("mis_flag", {31'b0, misaligned_out}, 32'h1);
    chk("mis_instr", instr_out, 32'h0000_0013);
    chk("mis_pc", pc_out, 32'h4000_0102);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_drained", {31'b0, instr_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h4000_0200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_recover", last_addr, 32'h4000_0200);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset with a full buffer
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_occ", {29'b0, occupancy}, 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_occ", {29'b0, occupancy}, 32'h0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rerst_pc", pc_out, 32'h4000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom % 100) != 0;
      rv = ($urandom % 16) == 0;
      rpc = 32'h4000_0000 + ($urandom_range(0, 255) << 2);
      if (($urandom % 4) == 0) rpc = rpc + 32'($urandom_range(1, 3));
      step(rn, ($urandom % 4) != 0, rv, rpc);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
